// File: rtl/puf_resp_collector.sv
// PUF response collector: seeds and steps an external challenge LFSR, majority-votes
// repeated PUF samples per challenge and packs the words into one wide response.
module puf_resp_collector #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned VOTES     = 1,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [WORD_W-1:0]                      challenge,
  output logic [WORD_W-1:0]                      lfsr_seed,
  output logic                                   lfsr_load,
  output logic                                   lfsr_next,
  input  logic                                   lfsr_done,
  input  logic [WORD_W-1:0]                      puf_data,
  output logic [WORD_W*NUM_WORDS-1:0]            resp,
  output logic                                   resp_valid,
  output logic                                   busy,
  output logic                                   err,
  output logic [$clog2(WORD_W*NUM_WORDS+1)-1:0]  unstable_cnt
);

  localparam int unsigned RW  = WORD_W * NUM_WORDS;
  localparam int unsigned UW  = $clog2(RW + 1);
  localparam int unsigned CW  = $clog2(VOTES + 1);
  localparam int unsigned VIW = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam int unsigned WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam int unsigned SW  = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_SETTLE, S_SAMPLE, S_COMMIT, S_STEP, S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [SW-1:0]               settle_q, settle_d;
  logic [VIW-1:0]              vote_q, vote_d;
  logic [WIW-1:0]              word_q, word_d;
  logic [WORD_W-1:0][CW-1:0]   vcnt_q, vcnt_d;
  logic [WORD_W-1:0]           seed_q, seed_d;
  logic [RW-1:0]               resp_q, resp_d;
  logic                        err_q, err_d;
  logic [UW-1:0]               unst_q, unst_d;
  logic                        load_q, next_q, valid_q, busy_q;
  logic [WORD_W-1:0]           word_c;
  logic [UW-1:0]               unst_add_c;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    settle_d   = '0;
    vote_d     = vote_q;
    word_d     = word_q;
    vcnt_d     = vcnt_q;
    seed_d     = seed_q;
    resp_d     = resp_q;
    err_d      = err_q;
    unst_d     = unst_q;
    word_c     = '0;
    unst_add_c = '0;

    // Majority result and unanimity check over the accumulated votes
    for (int unsigned b = 0; b < WORD_W; b++) begin
      word_c[b] = (vcnt_q[b] > CW'(VOTES / 2));
      if ((vcnt_q[b] != '0) && (vcnt_q[b] != CW'(VOTES))) begin
        unst_add_c = unst_add_c + UW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          seed_d  = challenge;
          err_d   = 1'b0;
          unst_d  = '0;
          word_d  = '0;
          vote_d  = '0;
          vcnt_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        // lfsr_done wins over a timeout reached in the same cycle
        if (lfsr_done) begin
          state_d = S_SETTLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        for (int unsigned b = 0; b < WORD_W; b++) begin
          vcnt_d[b] = vcnt_q[b] + CW'(puf_data[b]);
        end
        if (vote_q != VIW'(VOTES - 1)) begin
          vote_d  = vote_q + VIW'(1);
          state_d = S_SETTLE;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Word 0 lands in the most significant bits
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
          if (word_q == WIW'(w)) begin
            resp_d[RW-1-w*WORD_W -: WORD_W] = word_c;
          end
        end
        unst_d = unst_q + unst_add_c;
        vcnt_d = '0;
        vote_d = '0;
        if (word_q == WIW'(NUM_WORDS - 1)) begin
          state_d = S_DONE;
        end else begin
          word_d  = word_q + WIW'(1);
          state_d = S_STEP;
        end
      end
      S_STEP:  state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      settle_q <= '0;
      vote_q   <= '0;
      word_q   <= '0;
      vcnt_q   <= '0;
      seed_q   <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
      unst_q   <= '0;
      load_q   <= 1'b0;
      next_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      vote_q   <= vote_d;
      word_q   <= word_d;
      vcnt_q   <= vcnt_d;
      seed_q   <= seed_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      unst_q   <= unst_d;
      load_q   <= (state_d == S_LOAD);
      next_q   <= (state_d == S_STEP);
      valid_q  <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  assign lfsr_seed    = seed_q;
  assign lfsr_load    = load_q;
  assign lfsr_next    = next_q;
  assign resp         = resp_q;
  assign resp_valid   = valid_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign unstable_cnt = unst_q;

endmodule

// File: tb/tb_puf_resp_collector.sv
// Bench for puf_resp_collector: default instance plus a VOTES=3, NUM_WORDS=1 instance,
// with LFSR/PUF stubs and a queue of expected responses.
module tb_puf_resp_collector;

  localparam int unsigned W   = 16;
  localparam int unsigned RW  = 128;
  localparam int unsigned UW  = 8;
  localparam int unsigned UW3 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, lfsr_load, lfsr_next, lfsr_done;
  logic [W-1:0]  challenge, lfsr_seed, puf_data;
  logic [RW-1:0] resp;
  logic          resp_valid, busy, err;
  logic [UW-1:0] unstable_cnt;

  logic           start3, load3, next3, done3, valid3, busy3, err3;
  logic [W-1:0]   challenge3, seed3, puf3, resp3;
  logic [UW3-1:0] unst3;

  puf_resp_collector dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .lfsr_seed(lfsr_seed), .lfsr_load(lfsr_load), .lfsr_next(lfsr_next),
    .lfsr_done(lfsr_done), .puf_data(puf_data), .resp(resp),
    .resp_valid(resp_valid), .busy(busy), .err(err), .unstable_cnt(unstable_cnt)
  );

  puf_resp_collector #(.VOTES(3), .NUM_WORDS(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .challenge(challenge3),
    .lfsr_seed(seed3), .lfsr_load(load3), .lfsr_next(next3),
    .lfsr_done(done3), .puf_data(puf3), .resp(resp3),
    .resp_valid(valid3), .busy(busy3), .err(err3), .unstable_cnt(unst3)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_load = 0;
  int n_load = 0;
  int n_next = 0;
  int next_cyc[$];

  // LFSR stub answers two cycles after each pulse; PUF stub is constant or a word counter
  logic [1:0]   dly = '0;
  logic         mute = 1'b0;
  logic         pmode = 1'b0;
  logic [W-1:0] wc = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    dly <= {dly[0], lfsr_load | lfsr_next};
    if (lfsr_load) begin
      last_load <= cyc;
      n_load    <= n_load + 1;
      wc        <= 16'd1;
    end else if (lfsr_next) begin
      wc <= wc + 16'd1;
    end
    if (lfsr_next) begin
      n_next <= n_next + 1;
      next_cyc.push_back(cyc);
    end
  end
  assign lfsr_done = dly[1] & ~mute;
  assign puf_data  = pmode ? wc : 16'h1234;

  // Second stub: three differing samples, one per SETTLE+SAMPLE window
  logic [1:0] dly3 = '0;
  int k3 = 100;
  int last_load3 = 0;
  always @(posedge clk) begin
    dly3 <= {dly3[0], load3 | next3};
    if (load3) begin
      k3         <= 1;
      last_load3 <= cyc;
    end else if (k3 < 100) begin
      k3 <= k3 + 1;
    end
  end
  assign done3 = dly3[1];
  assign puf3  = (k3 <= 5) ? 16'hFFFF : (k3 <= 8) ? 16'h00FF : 16'h0F0F;

  typedef struct packed {
    logic [RW-1:0] r;
    logic [UW-1:0] u;
  } exp_t;
  exp_t sb[$];
  exp_t sb3[$];

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_start(input logic [W-1:0] ch);
    @(negedge clk);
    challenge = ch;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic push_exp(input logic [RW-1:0] r, input logic [UW-1:0] u);
    exp_t e;
    e.r = r;
    e.u = u;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_resp"}, resp, e.r);
    check({tag, "_unstable"}, RW'(unstable_cnt), RW'(e.u));
  endtask

  initial begin
    bit ok;
    int t0, bl, bn, qb, sp_bad;
    logic [RW-1:0] old_resp;
    exp_t e3;

    rst = 1'b1; start = 1'b0; challenge = '0; start3 = 1'b0; challenge3 = '0;
    repeat (3) @(negedge clk);
    check("rst_resp", resp, '0);
    check("rst_valid", RW'(resp_valid), '0);
    check("rst_busy", RW'(busy), '0);
    check("rst_err", RW'(err), '0);
    check("rst_unstable", RW'(unstable_cnt), '0);
    check("rst_pulses", RW'({lfsr_load, lfsr_next}), '0);
    check("rst_seed", RW'(lfsr_seed), '0);
    rst = 1'b0;

    // Constant PUF word, pulse counts and per-word timing
    bl = n_load; bn = n_next; qb = next_cyc.size();
    push_exp({8{16'h1234}}, '0);
    do_start(16'hACE1);
    t0 = cyc;
    check("t1_seed", RW'(lfsr_seed), RW'(16'hACE1));
    check("t1_load_pulse", RW'(lfsr_load), 1);
    check("t1_busy", RW'(busy), 1);
    wait_valid(ok);
    check("t1_valid_seen", RW'(ok), 1);
    check("t1_latency", RW'(cyc - t0), 56);
    pop_check("t1");
    check("t1_loads", RW'(n_load - bl), 1);
    check("t1_nexts", RW'(n_next - bn), 7);
    sp_bad = 0;
    if (next_cyc.size() >= qb + 7) begin
      if (next_cyc[qb] - t0 != 7) sp_bad++;
      for (int i = 1; i < 7; i++)
        if (next_cyc[qb+i] - next_cyc[qb+i-1] != 7) sp_bad++;
    end else begin
      sp_bad = 99;
    end
    check("t1_next_spacing", RW'(sp_bad), 0);
    check("t1_busy_done", RW'(busy), 0);

    // Distinct word per challenge, word 0 in MSBs; restart from DONE
    pmode = 1'b1;
    push_exp(128'h0001_0002_0003_0004_0005_0006_0007_0008, '0);
    do_start(16'hACE1);
    wait_valid(ok);
    check("t2_valid_seen", RW'(ok), 1);
    pop_check("t2");

    // Three votes, one word
    e3.r = RW'(16'h0FFF);
    e3.u = UW'(12);
    sb3.push_back(e3);
    @(negedge clk);
    challenge3 = 16'h1111;
    start3     = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    t0 = cyc;
    check("t3_seed", RW'(seed3), RW'(16'h1111));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid3) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_valid_seen", RW'(ok), 1);
    check("t3_latency", RW'(cyc - last_load3), 13);
    e3 = sb3.pop_front();
    check("t3_resp", RW'(resp3), e3.r);
    check("t3_unstable", RW'(unst3), RW'(e3.u));
    check("t3_idle_flags", RW'({busy3, err3}), 0);

    // Timeout with no lfsr_done, then recovery
    mute = 1'b1;
    pmode = 1'b0;
    bn = n_next;
    do_start(16'hBEEF);
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_err_seen", RW'(ok), 1);
    check("t4_err_cycle", RW'(cyc - t0), 256);
    check("t4_busy", RW'(busy), 0);
    check("t4_valid", RW'(resp_valid), 0);
    check("t4_nexts", RW'(n_next - bn), 0);
    mute = 1'b0;
    push_exp({8{16'h1234}}, '0);
    do_start(16'h1357);
    check("t4_err_cleared", RW'(err), 0);
    wait_valid(ok);
    check("t4_valid_seen", RW'(ok), 1);
    pop_check("t4");

    // start while busy is ignored; start in DONE restarts cleanly
    bl = n_load; bn = n_next;
    push_exp({8{16'h1234}}, '0);
    do_start(16'h2468);
    repeat (10) @(negedge clk);
    challenge = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    check("t5_valid_seen", RW'(ok), 1);
    pop_check("t5");
    check("t5_loads", RW'(n_load - bl), 1);
    check("t5_nexts", RW'(n_next - bn), 7);
    check("t5_seed", RW'(lfsr_seed), RW'(16'h2468));
    old_resp = resp;
    pmode = 1'b1;
    push_exp(128'h0001_0002_0003_0004_0005_0006_0007_0008, '0);
    do_start(16'h5A5A);
    check("t5_valid_drop", RW'(resp_valid), 0);
    check("t5_reload", RW'(lfsr_load), 1);
    check("t5_new_seed", RW'(lfsr_seed), RW'(16'h5A5A));
    check("t5_resp_kept", resp, old_resp);
    wait_valid(ok);
    check("t5b_valid_seen", RW'(ok), 1);
    pop_check("t5b");

    // Reset after word 3 commits
    pmode = 1'b0;
    bn = n_next;
    do_start(16'h0F0F);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_next - bn == 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_reached_word4", RW'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_resp", resp, '0);
    check("t6_flags", RW'({busy, err, resp_valid, lfsr_load, lfsr_next}), '0);
    check("t6_unstable", RW'(unstable_cnt), '0);
    rst = 1'b0;
    bl = n_load; bn = n_next;
    repeat (30) @(negedge clk);
    check("t6_no_pulses", RW'((n_load - bl) + (n_next - bn)), 0);
    check("t6_idle", RW'({busy, resp_valid}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
